// File: rtl/inst_mem_arbiter_pkg.sv
// Shared instruction-memory constants and arbiter types.
// Contents:
//   ADDR_WIDTH / DATA_WIDTH / MEM_INST_DEPTH : instruction memory geometry
//   INST_ARB_STARVE_DEFAULT                  : default starvation limit for the debug port
//   arb_state_e / arb_owner_e                : arbiter state and response owner encodings
//   addr_fault()                             : misaligned / out-of-range address check
package inst_mem_arbiter_pkg;

    localparam int ADDR_WIDTH              = 32;
    localparam int DATA_WIDTH              = 32;
    localparam int MEM_INST_DEPTH          = 1024;
    localparam int INST_ARB_STARVE_DEFAULT = 4;
    // Wide enough for any starvation limit in 1..15.
    localparam int STARVE_CNT_WIDTH        = 4;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_RESP = 1'b1
    } arb_state_e;

    typedef enum logic {
        OWN_F = 1'b0,
        OWN_D = 1'b1
    } arb_owner_e;

    // A fetch address faults when it is not word aligned or its word index
    // lies beyond the end of the instruction memory.
    function automatic logic addr_fault(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-3:0] word_idx_s;
        word_idx_s = addr[ADDR_WIDTH-1:2];
        return (addr[1:0] != 2'b00) ||
               (word_idx_s >= (ADDR_WIDTH-2)'(MEM_INST_DEPTH));
    endfunction

endpackage

// File: rtl/inst_arb_grant.sv
// Combinational grant selection between fetch (F) and debug (D) requesters.
// Ports:
//   can_accept  : arbiter may take a new request this cycle
//   f_valid     : fetch request valid
//   d_valid     : debug request valid
//   last_grant  : owner of the most recent grant (INST_ARB_RR_EN builds)
//   starve_cnt  : consecutive F wins while D waited (default build)
//   f_grant     : fetch request granted
//   d_grant     : debug request granted
// Build option: INST_ARB_RR_EN selects strict round-robin; otherwise fixed
// F-over-D priority with a starvation override for D.
module inst_arb_grant
    import inst_mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = INST_ARB_STARVE_DEFAULT
) (
    input  logic                        can_accept,
    input  logic                        f_valid,
    input  logic                        d_valid,
`ifdef INST_ARB_RR_EN
    input  arb_owner_e                  last_grant,
`else
    input  logic [STARVE_CNT_WIDTH-1:0] starve_cnt,
`endif
    output logic                        f_grant,
    output logic                        d_grant
);

`ifndef INST_ARB_RR_EN
    logic d_starved_s;

    // D has lost enough consecutive arbitrations to be forced through.
    assign d_starved_s = (starve_cnt >= STARVE_CNT_WIDTH'(STARVE_LIMIT));
`endif

    // Pick at most one winner; conflicts resolved by the configured policy.
    always_comb begin
        f_grant = 1'b0;
        d_grant = 1'b0;
        if (!can_accept) begin
            f_grant = 1'b0;
            d_grant = 1'b0;
        end else if (f_valid && d_valid) begin
`ifdef INST_ARB_RR_EN
            if (last_grant == OWN_F) begin
                d_grant = 1'b1;
            end else begin
                f_grant = 1'b1;
            end
`else
            if (d_starved_s) begin
                d_grant = 1'b1;
            end else begin
                f_grant = 1'b1;
            end
`endif
        end else if (f_valid) begin
            f_grant = 1'b1;
        end else if (d_valid) begin
            d_grant = 1'b1;
        end else begin
            f_grant = 1'b0;
            d_grant = 1'b0;
        end
    end

endmodule

// File: rtl/inst_mem_arbiter.sv
// Shares the combinational instruction-memory read port between the fetch
// stage (F) and the debug/loader port (D). One outstanding transaction,
// registered responses held until their owner accepts them; a new grant may
// be issued in the same cycle the held response is consumed.
// Ports:
//   clk, rst                        : clock, asynchronous active-high reset
//   f_req_valid/f_req_addr/f_req_ready     : fetch request handshake
//   f_resp_valid/f_resp_data/f_resp_fault/f_resp_ready : fetch response
//   d_req_* / d_resp_*              : same for the debug port
//   mem_addr                        : address driven to inst_mem (0 when idle)
//   mem_inst                        : combinational read data from inst_mem
// Build option: define INST_ARB_RR_EN for strict round-robin arbitration
// (starvation counter and STARVE_LIMIT are then unused).
module inst_mem_arbiter
    import inst_mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = INST_ARB_STARVE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  f_req_valid,
    input  logic [ADDR_WIDTH-1:0] f_req_addr,
    output logic                  f_req_ready,
    output logic                  f_resp_valid,
    output logic [DATA_WIDTH-1:0] f_resp_data,
    output logic                  f_resp_fault,
    input  logic                  f_resp_ready,
    input  logic                  d_req_valid,
    input  logic [ADDR_WIDTH-1:0] d_req_addr,
    output logic                  d_req_ready,
    output logic                  d_resp_valid,
    output logic [DATA_WIDTH-1:0] d_resp_data,
    output logic                  d_resp_fault,
    input  logic                  d_resp_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_inst
);

    arb_state_e            state_r;
    arb_state_e            state_nxt_s;
    arb_owner_e            owner_r;
    arb_owner_e            owner_nxt_s;
    logic                  f_resp_valid_r;
    logic                  f_valid_nxt_s;
    logic                  d_resp_valid_r;
    logic                  d_valid_nxt_s;
    logic [DATA_WIDTH-1:0] f_resp_data_r;
    logic                  f_resp_fault_r;
    logic [DATA_WIDTH-1:0] d_resp_data_r;
    logic                  d_resp_fault_r;
    logic                  resp_done_s;
    logic                  can_accept_s;
    logic                  f_grant_s;
    logic                  d_grant_s;
    logic [ADDR_WIDTH-1:0] grant_addr_s;
    logic                  grant_fault_s;
    logic [DATA_WIDTH-1:0] capture_data_s;

    // The held response is consumed this cycle; rst blocks every new grant.
    assign resp_done_s  = (state_r == ARB_RESP) &&
                          ((owner_r == OWN_F) ? (f_resp_valid_r && f_resp_ready)
                                              : (d_resp_valid_r && d_resp_ready));
    assign can_accept_s = !rst && ((state_r == ARB_IDLE) || resp_done_s);

`ifdef INST_ARB_RR_EN
    arb_owner_e last_grant_r;

    inst_arb_grant #(.STARVE_LIMIT(STARVE_LIMIT)) u_grant (
        .can_accept (can_accept_s),
        .f_valid    (f_req_valid),
        .d_valid    (d_req_valid),
        .last_grant (last_grant_r),
        .f_grant    (f_grant_s),
        .d_grant    (d_grant_s)
    );

    // Remember the last winner; reset to D so F takes the first conflict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_r <= OWN_D;
        end else if (f_grant_s) begin
            last_grant_r <= OWN_F;
        end else if (d_grant_s) begin
            last_grant_r <= OWN_D;
        end
    end
`else
    logic [STARVE_CNT_WIDTH-1:0] starve_cnt_r;

    inst_arb_grant #(.STARVE_LIMIT(STARVE_LIMIT)) u_grant (
        .can_accept (can_accept_s),
        .f_valid    (f_req_valid),
        .d_valid    (d_req_valid),
        .starve_cnt (starve_cnt_r),
        .f_grant    (f_grant_s),
        .d_grant    (d_grant_s)
    );

    // Count consecutive F wins that D sat through; the grant logic never
    // lets it pass STARVE_LIMIT, so no saturation is needed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_r <= '0;
        end else if (d_grant_s || !d_req_valid) begin
            starve_cnt_r <= '0;
        end else if (f_grant_s) begin
            starve_cnt_r <= starve_cnt_r + STARVE_CNT_WIDTH'(1);
        end
    end
`endif

    // Route the winner's address to the memory and derive its fault flag.
    always_comb begin
        grant_addr_s = '0;
        if (f_grant_s) begin
            grant_addr_s = f_req_addr;
        end else if (d_grant_s) begin
            grant_addr_s = d_req_addr;
        end else begin
            grant_addr_s = '0;
        end
    end

    assign grant_fault_s  = addr_fault(grant_addr_s);
    assign capture_data_s = grant_fault_s ? '0 : mem_inst;

    // Next state / owner / response-valid: a grant always wins over a plain
    // completion so back-to-back transfers keep state in RESP.
    always_comb begin
        state_nxt_s   = state_r;
        owner_nxt_s   = owner_r;
        f_valid_nxt_s = f_resp_valid_r;
        d_valid_nxt_s = d_resp_valid_r;
        if (f_grant_s || d_grant_s) begin
            state_nxt_s   = ARB_RESP;
            owner_nxt_s   = d_grant_s ? OWN_D : OWN_F;
            f_valid_nxt_s = f_grant_s;
            d_valid_nxt_s = d_grant_s;
        end else if (resp_done_s) begin
            state_nxt_s   = ARB_IDLE;
            f_valid_nxt_s = 1'b0;
            d_valid_nxt_s = 1'b0;
        end else begin
            state_nxt_s   = state_r;
        end
    end

    // State, owner and response-valid registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= ARB_IDLE;
            owner_r        <= OWN_F;
            f_resp_valid_r <= 1'b0;
            d_resp_valid_r <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            owner_r        <= owner_nxt_s;
            f_resp_valid_r <= f_valid_nxt_s;
            d_resp_valid_r <= d_valid_nxt_s;
        end
    end

    // Per-port response payload, written only on that port's grant so it
    // stays stable while the response waits for its owner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_resp_data_r  <= '0;
            f_resp_fault_r <= 1'b0;
            d_resp_data_r  <= '0;
            d_resp_fault_r <= 1'b0;
        end else if (f_grant_s) begin
            f_resp_data_r  <= capture_data_s;
            f_resp_fault_r <= grant_fault_s;
        end else if (d_grant_s) begin
            d_resp_data_r  <= capture_data_s;
            d_resp_fault_r <= grant_fault_s;
        end
    end

    assign f_req_ready  = f_grant_s;
    assign d_req_ready  = d_grant_s;
    assign mem_addr     = grant_addr_s;
    assign f_resp_valid = f_resp_valid_r;
    assign f_resp_data  = f_resp_data_r;
    assign f_resp_fault = f_resp_fault_r;
    assign d_resp_valid = d_resp_valid_r;
    assign d_resp_data  = d_resp_data_r;
    assign d_resp_fault = d_resp_fault_r;

endmodule

// File: tb/tb_inst_mem_arbiter.sv
// Self-checking bench for inst_mem_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_inst_mem_arbiter;
    import inst_mem_arbiter_pkg::*;

    localparam int LIMIT = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  f_req_valid, f_req_ready, f_resp_valid, f_resp_fault, f_resp_ready;
    logic                  d_req_valid, d_req_ready, d_resp_valid, d_resp_fault, d_resp_ready;
    logic [ADDR_WIDTH-1:0] f_req_addr, d_req_addr, mem_addr;
    logic [DATA_WIDTH-1:0] f_resp_data, d_resp_data, mem_inst;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Memory image: word i holds the value i.
    assign mem_inst = {2'b00, mem_addr[ADDR_WIDTH-1:2]};

    inst_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .f_req_valid(f_req_valid), .f_req_addr(f_req_addr), .f_req_ready(f_req_ready),
        .f_resp_valid(f_resp_valid), .f_resp_data(f_resp_data), .f_resp_fault(f_resp_fault),
        .f_resp_ready(f_resp_ready),
        .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_ready(d_req_ready),
        .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data), .d_resp_fault(d_resp_fault),
        .d_resp_ready(d_resp_ready),
        .mem_addr(mem_addr), .mem_inst(mem_inst)
    );

    // ---------------- reference model (transaction level) ----------------
    bit          m_held;       // a response is outstanding
    int          m_owner;      // 0 = F, 1 = D
    logic [31:0] m_data;
    bit          m_fault;
    int          m_d_losses;   // consecutive arbitrations D lost while valid
    int          m_last;       // last winner, 0 = F, 1 = D
    int          m_win;        // this cycle's winner, -1 none
    bit          m_ok;         // a new request may be taken this cycle

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        return a / 32'd4;
    endfunction

    function automatic bit ref_fault(input logic [31:0] a);
        return (a % 32'd4 != 32'd0) || (a / 32'd4 >= 32'(MEM_INST_DEPTH));
    endfunction

    task automatic model_reset();
        m_held = 1'b0; m_d_losses = 0; m_last = 1; m_win = -1; m_ok = 1'b1;
    endtask

    task automatic model_arb();
        m_ok  = !m_held || (m_owner == 0 ? f_resp_ready : d_resp_ready);
        m_win = -1;
        if (m_ok) begin
            if (f_req_valid && d_req_valid) begin
`ifdef INST_ARB_RR_EN
                m_win = (m_last == 0) ? 1 : 0;
`else
                m_win = (m_d_losses >= LIMIT) ? 1 : 0;
`endif
            end else if (f_req_valid) m_win = 0;
            else if (d_req_valid) m_win = 1;
        end
    endtask

    task automatic model_commit();
        logic [31:0] a;
        a = (m_win == 0) ? f_req_addr : d_req_addr;
        if (m_win >= 0) begin
            m_held = 1'b1; m_owner = m_win; m_last = m_win;
            m_fault = ref_fault(a);
            m_data  = m_fault ? 32'd0 : ref_word(a);
        end else if (m_ok && m_held) begin
            m_held = 1'b0;
        end
        if (!d_req_valid || m_win == 1) m_d_losses = 0;
        else if (m_win == 0) m_d_losses = m_d_losses + 1;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 3))
            0, 1:    a = 32'($urandom_range(0, MEM_INST_DEPTH - 1)) << 2;
            2:       a = (32'($urandom_range(0, MEM_INST_DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
            default: a = (32'(MEM_INST_DEPTH) + 32'($urandom_range(0, 4000))) << 2;
        endcase
        return a;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        f_req_valid = 1'b0; d_req_valid = 1'b0; f_resp_ready = 1'b0; d_resp_ready = 1'b0;
        f_req_addr = 32'd0; d_req_addr = 32'd0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        f_req_valid = 1'b1; f_req_addr = 32'd4; d_req_valid = 1'b1; d_req_addr = 32'd8;
        f_resp_ready = 1'b1; d_resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if ({f_req_ready, d_req_ready} !== 2'b00) begin miscompares++;
            $display("FAIL reset_ready got %b want 00", {f_req_ready, d_req_ready}); end
        vectors++; if (mem_addr !== 32'd0) begin miscompares++;
            $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
        vectors++; if ({f_resp_valid, d_resp_valid, f_resp_fault, d_resp_fault} !== 4'b0000) begin miscompares++;
            $display("FAIL reset_resp_flags got %b want 0000", {f_resp_valid, d_resp_valid, f_resp_fault, d_resp_fault}); end
        vectors++; if ((f_resp_data | d_resp_data) !== 32'd0) begin miscompares++;
            $display("FAIL reset_resp_data got %h/%h want 0", f_resp_data, d_resp_data); end
        f_req_valid = 1'b0; d_req_valid = 1'b0;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_f_back_to_back();
        f_resp_ready = 1'b1; d_resp_ready = 1'b1; d_req_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            f_req_valid = 1'b1; f_req_addr = 32'(k * 4);
            #1;
            vectors++; if (f_req_ready !== 1'b1 || mem_addr !== 32'(k * 4)) begin miscompares++;
                $display("FAIL b2b_grant[%0d] ready %b addr %h want 1 %h", k, f_req_ready, mem_addr, k * 4); end
            @(posedge clk); #1;
            vectors++; if (f_resp_valid !== 1'b1 || f_resp_data !== 32'(k) || f_resp_fault !== 1'b0) begin miscompares++;
                $display("FAIL b2b_resp[%0d] v %b d %h f %b want 1 %h 0", k, f_resp_valid, f_resp_data, f_resp_fault, k); end
        end
        f_req_valid = 1'b0;
        @(posedge clk); #1;
        vectors++; if (f_resp_valid !== 1'b0) begin miscompares++;
            $display("FAIL b2b_drain got %b want 0", f_resp_valid); end
    endtask

    task automatic test_faults();
        logic [31:0] addrs [3];
        logic [31:0] exp_d [3];
        logic        exp_f [3];
        addrs[0] = 32'h6;                        exp_d[0] = 32'd0;   exp_f[0] = 1'b1;
        addrs[1] = 32'(MEM_INST_DEPTH * 4);      exp_d[1] = 32'd0;   exp_f[1] = 1'b1;
        addrs[2] = 32'((MEM_INST_DEPTH - 1) * 4); exp_d[2] = 32'(MEM_INST_DEPTH - 1); exp_f[2] = 1'b0;
        f_resp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            f_req_valid = 1'b1; f_req_addr = addrs[k];
            @(posedge clk); #1;
            f_req_valid = 1'b0;
            vectors++; if (f_resp_valid !== 1'b1 || f_resp_fault !== exp_f[k] || f_resp_data !== exp_d[k]) begin miscompares++;
                $display("FAIL fault[%h] v %b f %b d %h want 1 %b %h", addrs[k], f_resp_valid, f_resp_fault, f_resp_data, exp_f[k], exp_d[k]); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_arbitration();
        logic exp_d;
        do_reset();
        f_req_valid = 1'b1; f_req_addr = 32'h40; d_req_valid = 1'b1; d_req_addr = 32'h80;
        f_resp_ready = 1'b1; d_resp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
`ifdef INST_ARB_RR_EN
            exp_d = (i % 2 == 1);
`else
            exp_d = (i % (LIMIT + 1) == LIMIT);
`endif
            vectors++; if ({f_req_ready, d_req_ready} !== (exp_d ? 2'b01 : 2'b10)) begin miscompares++;
                $display("FAIL arb_seq[%0d] f/d ready %b want %b", i, {f_req_ready, d_req_ready}, exp_d ? 2'b01 : 2'b10); end
            @(posedge clk);
        end
        #1;
        f_req_valid = 1'b0; d_req_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_d_hold();
        do_reset();
        d_req_valid = 1'b1; d_req_addr = 32'h10; d_resp_ready = 1'b0; f_resp_ready = 1'b1;
        #1;
        vectors++; if (d_req_ready !== 1'b1) begin miscompares++;
            $display("FAIL hold_d_grant got %b want 1", d_req_ready); end
        @(posedge clk); #1;
        d_req_valid = 1'b0; f_req_valid = 1'b1; f_req_addr = 32'h20;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++; if (d_resp_valid !== 1'b1 || d_resp_data !== 32'd4 || d_resp_fault !== 1'b0 || f_req_ready !== 1'b0) begin miscompares++;
                $display("FAIL hold_stable[%0d] dv %b dd %h df %b fr %b want 1 4 0 0", i, d_resp_valid, d_resp_data, d_resp_fault, f_req_ready); end
            @(posedge clk);
        end
        #1;
        d_resp_ready = 1'b1;
        #1;
        vectors++; if (f_req_ready !== 1'b1 || mem_addr !== 32'h20) begin miscompares++;
            $display("FAIL hold_release ready %b addr %h want 1 20", f_req_ready, mem_addr); end
        @(posedge clk); #1;
        f_req_valid = 1'b0;
        vectors++; if (f_resp_valid !== 1'b1 || f_resp_data !== 32'd8 || d_resp_valid !== 1'b0) begin miscompares++;
            $display("FAIL hold_switch fv %b fd %h dv %b want 1 8 0", f_resp_valid, f_resp_data, d_resp_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        f_req_valid = 1'b1; f_req_addr = 32'hC; f_resp_ready = 1'b0;
        @(posedge clk); #1;
        vectors++; if (f_resp_valid !== 1'b1) begin miscompares++;
            $display("FAIL rstmid_pre got %b want 1", f_resp_valid); end
        #2; rst = 1'b1; #1;
        vectors++; if (f_resp_valid !== 1'b0 || d_resp_valid !== 1'b0) begin miscompares++;
            $display("FAIL rstmid_drop f %b d %b want 0 0", f_resp_valid, d_resp_valid); end
        vectors++; if (f_req_ready !== 1'b0) begin miscompares++;
            $display("FAIL rstmid_nogrant got %b want 0", f_req_ready); end
        @(posedge clk); #1;
        rst = 1'b0; f_req_valid = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (f_resp_valid !== 1'b0 || d_resp_valid !== 1'b0) begin miscompares++;
            $display("FAIL rstmid_after f %b d %b want 0 0", f_resp_valid, d_resp_valid); end
        f_req_valid = 1'b1; f_req_addr = 32'h0;
        #1;
        vectors++; if (f_req_ready !== 1'b1) begin miscompares++;
            $display("FAIL rstmid_idle ready got %b want 1", f_req_ready); end
        @(posedge clk); #1;
        f_req_valid = 1'b0; f_resp_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        bit f_won, d_won;
        logic [31:0] exp_addr;
        do_reset();
        f_won = 1'b1; d_won = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if (!f_req_valid || f_won) begin f_req_valid = 1'($urandom_range(0, 1)); f_req_addr = rand_addr(); end
            if (!d_req_valid || d_won) begin d_req_valid = 1'($urandom_range(0, 1)); d_req_addr = rand_addr(); end
            f_resp_ready = ($urandom_range(0, 3) != 0);
            d_resp_ready = ($urandom_range(0, 3) != 0);
            #1;
            model_arb();
            exp_addr = (m_win == 0) ? f_req_addr : (m_win == 1) ? d_req_addr : 32'd0;
            vectors++; if (f_req_ready !== (m_win == 0) || d_req_ready !== (m_win == 1) || mem_addr !== exp_addr) begin miscompares++;
                $display("FAIL rnd_grant[%0d] f/d %b%b addr %h want %b%b %h", n, f_req_ready, d_req_ready, mem_addr, m_win == 0, m_win == 1, exp_addr); end
            @(posedge clk);
            model_commit();
            f_won = (m_win == 0); d_won = (m_win == 1);
            #1;
            vectors++; if (f_resp_valid !== (m_held && m_owner == 0) || d_resp_valid !== (m_held && m_owner == 1)) begin miscompares++;
                $display("FAIL rnd_valid[%0d] f/d %b%b want %b%b", n, f_resp_valid, d_resp_valid, m_held && m_owner == 0, m_held && m_owner == 1); end
            if (m_held) begin
                vectors++;
                if ((m_owner == 0 && (f_resp_data !== m_data || f_resp_fault !== m_fault)) ||
                    (m_owner == 1 && (d_resp_data !== m_data || d_resp_fault !== m_fault))) begin miscompares++;
                    $display("FAIL rnd_payload[%0d] owner %0d f %h/%b d %h/%b want %h/%b", n, m_owner, f_resp_data, f_resp_fault, d_resp_data, d_resp_fault, m_data, m_fault); end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        f_req_valid = 1'b0; d_req_valid = 1'b0; f_resp_ready = 1'b0; d_resp_ready = 1'b0;
        f_req_addr = 32'd0; d_req_addr = 32'd0;
        model_reset();
        test_reset();
        test_f_back_to_back();
        test_faults();
        test_arbitration();
        test_d_hold();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
